// File: rtl/div_unit.sv
// Multi-cycle radix-2 non-restoring divider for RISC-V DIV/DIVU/REM/REMU.
// Optional last-result cache enabled by defining DIV_RESULT_CACHE_EN.
module div_unit #(
  parameter int unsigned DW   = 32,
  parameter int unsigned TAGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [1:0]      op_i,
  input  logic [DW-1:0]   dividend_i,
  input  logic [DW-1:0]   divisor_i,
  input  logic [TAGW-1:0] tag_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [DW-1:0]   result_o,
  output logic [TAGW-1:0] tag_o
);

  localparam int unsigned      CW     = $clog2(DW) + 1;
  localparam logic [CW-1:0]    LAST   = CW'(DW - 1);
  localparam logic [DW-1:0]    MIN_NEG = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [DW:0]     prem;
  logic [DW-1:0]   quot;
  logic [DW-1:0]   dvsr;
  logic [TAGW-1:0] tag_q;
  logic            rem_q, q_neg, r_neg;

  logic            accept, special, hit, load_res, cache_wr;
  logic            dvd_neg, dvs_neg;
  logic [DW-1:0]   abs_dvd, abs_dvs, early_q, early_r;
  logic [DW:0]     shifted, p_new;
  logic [DW-1:0]   q_new, r_mag, fin_q, fin_r;
  logic [DW-1:0]   res_nx;
  logic [TAGW-1:0] tag_nx;

`ifdef DIV_RESULT_CACHE_EN
  logic            c_valid, c_uns, uns_q;
  logic [DW-1:0]   c_dvd, c_dvs, c_q, c_r, raw_dvd, raw_dvs;
`endif

  always_comb begin
    dvd_neg = !op_i[0] && dividend_i[DW-1];
    dvs_neg = !op_i[0] && divisor_i[DW-1];
    abs_dvd = dvd_neg ? -dividend_i : dividend_i;
    abs_dvs = dvs_neg ? -divisor_i  : divisor_i;

    // Special cases resolve at accept without iterating.
    special = 1'b0;
    hit     = 1'b0;
    early_q = '1;
    early_r = dividend_i;
    if (divisor_i == '0) begin
      special = 1'b1;
    end else if (!op_i[0] && dividend_i == MIN_NEG && divisor_i == '1) begin
      special = 1'b1;
      early_q = dividend_i;
      early_r = '0;
    end
`ifdef DIV_RESULT_CACHE_EN
    else if (c_valid && c_dvd == dividend_i && c_dvs == divisor_i && c_uns == op_i[0]) begin
      hit     = 1'b1;
      early_q = c_q;
      early_r = c_r;
    end
`endif

    // One non-restoring step; the partial remainder wraps modulo 2^(DW+1)
    // but the post-step value always fits, so the sign test stays exact.
    shifted = {prem[DW-1:0], quot[DW-1]};
    p_new   = prem[DW] ? shifted + {1'b0, dvsr} : shifted - {1'b0, dvsr};
    q_new   = {quot[DW-2:0], ~p_new[DW]};
    r_mag   = p_new[DW] ? p_new[DW-1:0] + dvsr : p_new[DW-1:0];
    fin_q   = q_neg ? -q_new : q_new;
    fin_r   = r_neg ? -r_mag : r_mag;
  end

  always_comb begin
    state_nx = state;
    load_res = 1'b0;
    cache_wr = 1'b0;
    res_nx   = result_o;
    tag_nx   = tag_o;
    accept   = start_i && !flush_i && (state != CALC);
    if (flush_i) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE, FIN: begin
          state_nx = IDLE;
          if (start_i) begin
            if (special || hit) begin
              state_nx = FIN;
              load_res = 1'b1;
              res_nx   = op_i[1] ? early_r : early_q;
              tag_nx   = tag_i;
            end else begin
              state_nx = CALC;
            end
          end
        end
        CALC: begin
          if (cnt == LAST) begin
            state_nx = FIN;
            load_res = 1'b1;
            cache_wr = 1'b1;
            res_nx   = rem_q ? fin_r : fin_q;
            tag_nx   = tag_q;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      busy_o   <= 1'b0;
      valid_o  <= 1'b0;
      result_o <= '0;
      tag_o    <= '0;
      cnt      <= '0;
      prem     <= '0;
      quot     <= '0;
      dvsr     <= '0;
      tag_q    <= '0;
      rem_q    <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
    end else begin
      state   <= state_nx;
      busy_o  <= (state_nx == CALC);
      valid_o <= (state_nx == FIN);
      if (load_res) begin
        result_o <= res_nx;
        tag_o    <= tag_nx;
      end
      if (accept) begin
        cnt   <= '0;
        prem  <= '0;
        quot  <= abs_dvd;
        dvsr  <= abs_dvs;
        tag_q <= tag_i;
        rem_q <= op_i[1];
        q_neg <= dvd_neg ^ dvs_neg;
        r_neg <= dvd_neg;
      end else if (state == CALC) begin
        cnt  <= cnt + CW'(1);
        prem <= p_new;
        quot <= q_new;
      end
    end
  end

`ifdef DIV_RESULT_CACHE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_valid <= 1'b0;
      c_uns   <= 1'b0;
      c_dvd   <= '0;
      c_dvs   <= '0;
      c_q     <= '0;
      c_r     <= '0;
      uns_q   <= 1'b0;
      raw_dvd <= '0;
      raw_dvs <= '0;
    end else begin
      if (accept) begin
        uns_q   <= op_i[0];
        raw_dvd <= dividend_i;
        raw_dvs <= divisor_i;
      end
      if (flush_i) begin
        c_valid <= 1'b0;
      end else if (cache_wr) begin
        c_valid <= 1'b1;
        c_uns   <= uns_q;
        c_dvd   <= raw_dvd;
        c_dvs   <= raw_dvs;
        c_q     <= fin_q;
        c_r     <= fin_r;
      end
    end
  end
`endif

endmodule

// File: doc/div_unit.md
# div_unit

Parametrised, multi-cycle radix-2 integer divider for the RISC-V M-extension execute stage, succeeding the fixed 32-bit divider. It executes DIV/DIVU/REM/REMU with architecturally exact RISC-V results, including divide-by-zero and signed overflow. It uses a start/valid handshake with a destination tag, supports pipeline flush, and optionally caches the last quotient/remainder pair so that a DIV followed by a REM on the same operands completes in one cycle.

## Interface
- DW, 32: operand/result width; any value ≥ 4.
- TAGW, 5: width of the pass-through tag (rd index).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  request; accepted only when busy_o=0.
- flush_i  in  1  abort the in-flight operation; no result is produced.
- op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; op_i[0]=1 selects unsigned.
- dividend_i  in  DW  rs1 operand.
- divisor_i  in  DW  rs2 operand.
- tag_i  in  TAGW  captured at accept.
- busy_o  out  1  high in CALC; reset value 0.
- valid_o  out  1  one-cycle result strobe; reset value 0.
- result_o  out  DW  quotient or remainder per op; holds until next valid_o; reset value 0.
- tag_o  out  TAGW  tag of the result on result_o; reset value 0.

## Operation
- States: IDLE, CALC, FIN. Reset → IDLE, cycle counter 0, cache invalid.
- IDLE/FIN + start_i & !flush_i → accept: latch op, tag, and |operands| (signed ops); record sign of quotient (dividend sign XOR divisor sign) and sign of remainder (dividend sign).
- At accept, a special case or cache hit → FIN directly; otherwise → CALC.
- CALC: one non-restoring iteration per cycle, using a DW+1-bit partial remainder and a log2(DW)+1-bit counter; after DW iterations → FIN. Final remainder correction (add divisor back if negative) is applied entering FIN.
- FIN: valid_o=1, result_o/tag_o driven. → IDLE unless a new start is accepted in the same cycle (back-to-back allowed).
- Sign fix-up: quotient negated if its sign bit is set; remainder negated if dividend negative. Quotient truncates toward zero.
- Divide by zero: quotient = all ones; remainder = dividend (unmodified). Holds for signed and unsigned.
- Signed overflow (dividend = 1<<(DW-1), divisor = all ones, signed op): quotient = dividend; remainder = 0.
- flush_i in any state: → IDLE next edge; valid_o is not asserted and cache is invalidated. flush_i wins over a simultaneous start_i.
- start_i while busy_o=1: ignored, no effect.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous); no valid_o.

## Timing
- start_i sampled high in cycle 0. Normal path: CALC in cycles 1..DW, valid_o in cycle DW+1 (DW=32 → cycle 33).
- Special cases and cache hits: valid_o in cycle 1; busy_o never asserted.
- busy_o is low in FIN, so a start in the FIN cycle is accepted. Issue rate: one op per DW+1 cycles, or one per cycle for special/hit streams.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- DIV_RESULT_CACHE_EN defined: store dividend, divisor, signedness (op_i[0]), quotient and remainder at every normally completed FIN. A later accept with identical operands and signedness is a hit; it returns the quotient or remainder per op_i[1] with 1-cycle latency. The cache is invalidated by reset and flush.
- Undefined: no cache storage; every non-special op takes DW+1 cycles.

## Test plan
- DW=32: DIVU 100/7 → result_o=14, valid_o in cycle 33, busy_o high in cycles 1..32, tag_o=tag_i.
- DIV 0xFFFFFFF9 (-7)/2 → 0xFFFFFFFD; then REM same operands → 0xFFFFFFFF. The REM has latency 1 with DIV_RESULT_CACHE_EN and 33 without.
- DIV 5/0 → 0xFFFFFFFF, REMU 5/0 → 5; each valid_o in cycle 1.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0; latency 1.
- DIVU 9/3 started, flush_i in cycle 10: no valid_o, busy_o low from cycle 11. Reissue of DIVU 9/3 → 3 in 33 cycles (cache cleared).
- rst low in cycle 5 of CALC: busy_o/valid_o/result_o immediately 0. After release, REMU 10/4 → 2 in cycle 33.
